vga_timing_gen: RTL and testbench

- Generates the raster scan consumed by the sprite and tile renderers.
- Drives horizontal and vertical counters at the pixel clock and outputs DrawX, DrawY and blank, which is active-high during visible video.
- Outputs HS and VS sync pulses delayed by a programmable number of cycles, so the syncs stay aligned with the registered ROM-plus-palette pixel pipeline downstream.
- Also provides frame/line strobes and a frame counter for game-logic timing.

---
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster-scan timing for the sprite/tile renderers.
//
// Ports:
//   vga_clk      in   pixel clock
//   reset        in   asynchronous reset, active-high
//   DrawX        out  [9:0] horizontal count, 0..H_TOTAL-1
//   DrawY        out  [9:0] vertical count,   0..V_TOTAL-1
//   blank        out  1 = visible pixel at the current DrawX/DrawY
//   hs, vs       out  active-low syncs, delayed SYNC_DELAY clocks behind DrawX/DrawY
//   line_start   out  one-cycle pulse on each horizontal wrap to DrawX==0
//   frame_start  out  one-cycle pulse on each full-frame wrap to (0,0)
//   frame_count  out  [7:0] frames completed since reset, modulo 256
//
// All outputs come straight from flops. Every registered output is computed
// from the next-state counter values, so it lines up with the DrawX/DrawY
// that are registered on the same edge.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       blank_q, blank_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       h_wrap, v_wrap;
  logic       hs_raw_d, vs_raw_d;

  // Sync delay lines. Stage 0 is the raw sync registered alongside DrawX/DrawY;
  // stages 1..SYNC_DELAY are the extra pipeline matching the pixel path.
  logic [SYNC_DELAY:0] hs_pipe_q, hs_pipe_d;
  logic [SYNC_DELAY:0] vs_pipe_q, vs_pipe_d;

  always_comb begin
    h_wrap = (x_q == H_LAST);
    v_wrap = h_wrap && (y_q == V_LAST);

    x_d = h_wrap ? 10'd0 : x_q + 10'd1;
    if (v_wrap)      y_d = 10'd0;
    else if (h_wrap) y_d = y_q + 10'd1;
    else             y_d = y_q;

    blank_d  = (x_d < H_VIS) && (y_d < V_VIS);
    hs_raw_d = !((x_d >= HS_START) && (x_d < HS_END));
    vs_raw_d = !((y_d >= VS_START) && (y_d < VS_END));

    // A wrap on this edge means the counters land on DrawX==0 (and (0,0)).
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    frame_count_d = frame_count_q + {7'd0, v_wrap};
  end

  if (SYNC_DELAY > 0) begin : g_sync_dly
    always_comb begin
      hs_pipe_d = {hs_pipe_q[SYNC_DELAY-1:0], hs_raw_d};
      vs_pipe_d = {vs_pipe_q[SYNC_DELAY-1:0], vs_raw_d};
    end
  end else begin : g_sync_nodly
    always_comb begin
      hs_pipe_d = hs_raw_d;
      vs_pipe_d = vs_raw_d;
    end
  end

  // The whole delay line resets to idle-high so no stale sync pulse
  // emerges after a mid-frame reset.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      blank_q       <= 1'b1;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= blank_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = hs_pipe_q[SYNC_DELAY];
  assign vs          = vs_pipe_q[SYNC_DELAY];
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Two instances share clock and reset:
//   dut_s : small timing set (15x10 raster), SYNC_DELAY=2 -- exercises full
//           frames, vs, blank corners and the 256-frame counter wrap.
//   dut_d : default 800x525 timing, SYNC_DELAY=0 -- exercises the real hs
//           window and line strobes over the first few dozen lines.
// The reference model derives every output from n, the number of clock edges
// since reset release, using plain division/modulo on the raster totals.
module tb_vga_timing_gen;

  // Small timing set
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_SD = 2;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;   // 15
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;   // 10

  // Default timing set
  localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VA = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
  localparam int D_SD = 0;

  // ---------------- clock / reset ----------------
  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 vga_clk = ~vga_clk;

  logic [9:0] x_s, y_s, x_d, y_d;
  logic       blank_s, hs_s, vs_s, ls_s, fs_s;
  logic       blank_d, hs_d, vs_d, ls_d, fs_d;
  logic [7:0] fc_s, fc_d;

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_DELAY(S_SD)
  ) dut_s (
    .vga_clk(vga_clk), .reset(reset),
    .DrawX(x_s), .DrawY(y_s), .blank(blank_s), .hs(hs_s), .vs(vs_s),
    .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  vga_timing_gen #(
    .H_ACTIVE(D_HA), .H_FP(D_HF), .H_SYNC(D_HS), .H_BP(D_HB),
    .V_ACTIVE(D_VA), .V_FP(D_VF), .V_SYNC(D_VS), .V_BP(D_VB),
    .SYNC_DELAY(D_SD)
  ) dut_d (
    .vga_clk(vga_clk), .reset(reset),
    .DrawX(x_d), .DrawY(y_d), .blank(blank_d), .hs(hs_d), .vs(vs_d),
    .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  // ---------------- scoreboard ----------------
  int unsigned n;          // clock edges since reset release
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          fs_wraps_seen = 0;   // dut_s frame_start pulses where frame_count went to 0

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s @n=%0d: got %0d expected %0d", tag, n, obs, exp);
    end
  endtask

  // Reference: raster position after n edges, syncs from the position SD edges earlier.
  task automatic check_model(
    input string who,
    input int ha, input int hf, input int hsw, input int hb,
    input int va, input int vf, input int vsw, input int vb, input int sd,
    input logic [9:0] ox, input logic [9:0] oy, input logic oblank,
    input logic ohs, input logic ovs, input logic ols, input logic ofs,
    input logic [7:0] ofc
  );
    int ht, vt, ex, ey, m, mx, my;
    logic ehs, evs;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    ex = int'(n % ht);
    ey = int'((n / ht) % vt);
    if (n < sd) begin
      ehs = 1'b1;
      evs = 1'b1;
    end else begin
      m   = int'(n) - sd;
      mx  = m % ht;
      my  = (m / ht) % vt;
      ehs = !(mx >= ha + hf && mx < ha + hf + hsw);
      evs = !(my >= va + vf && my < va + vf + vsw);
    end
    check_eq({who, ".DrawX"},       32'(ox),     32'(ex));
    check_eq({who, ".DrawY"},       32'(oy),     32'(ey));
    check_eq({who, ".blank"},       32'(oblank), 32'(ex < ha && ey < va));
    check_eq({who, ".hs"},          32'(ohs),    32'(ehs));
    check_eq({who, ".vs"},          32'(ovs),    32'(evs));
    check_eq({who, ".line_start"},  32'(ols),    32'(n > 0 && ex == 0));
    check_eq({who, ".frame_start"}, 32'(ofs),    32'(n > 0 && ex == 0 && ey == 0));
    check_eq({who, ".frame_count"}, 32'(ofc),    (n / (ht * vt)) % 256);
  endtask

  task automatic check_both();
    check_model("s", S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_SD,
                x_s, y_s, blank_s, hs_s, vs_s, ls_s, fs_s, fc_s);
    check_model("d", D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, D_SD,
                x_d, y_d, blank_d, hs_d, vs_d, ls_d, fs_d, fc_d);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge vga_clk);
    if (!reset) n++;
    @(negedge vga_clk);
    if (fs_s && fc_s == 8'd0) fs_wraps_seen++;
    check_both();
  endtask

  // Asynchronous reset from mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset(input int hold);
    reset = 1'b1;
    #1;
    n = 0;
    check_both();
    repeat (hold) step();
    reset = 1'b0;
  endtask

  initial begin
    n = 0;
    // Reset held from time zero.
    repeat (3) step();
    reset = 1'b0;

    // First lines of the default raster and many small frames.
    repeat (200) step();

    // Reset while dut_s has sync-low values inside its delay line.
    for (int i = 0; i < S_HT && (n % S_HT) != S_HA + S_HF + 1; i++) step();
    do_reset(3);

    // Randomized reset points and hold lengths.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(20, 400)) step();
      do_reset($urandom_range(1, 4));
    end

    // Long run: 257 small frames so frame_count wraps 255 -> 0.
    repeat (257 * S_HT * S_VT + 20) step();
    check_eq("s.frame_count_wrap_seen", 32'(fs_wraps_seen), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
